// File: rtl/adder_8bit_pkg.sv
// ============================================================================
// Module : adder_8bit_pkg
// Brief  : Shared constants and result type for the registered ripple adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

endpackage : adder_8bit_pkg

`default_nettype wire

// File: rtl/adder_8bit_full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : Purely combinational 1-bit full-adder cell.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ cin;
    assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder

`default_nettype wire

// File: rtl/adder_8bit.sv
// ============================================================================
// Module : adder_8bit
// Brief  : Registered WIDTH-bit ripple-carry adder, sum = a + b + carry_in.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_8bit
    import adder_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    out_state_e       state_q, state_d;

    assign w_carry[0] = carry_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_carry[i]),
                .s    (w_sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    // Operands only reach state when in_valid is high, so idle X's never leak in.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        state_d = OUT_IDLE;
        if (in_valid) begin
            sum_d   = w_sum;
            carry_d = w_carry[WIDTH];
            state_d = OUT_VALID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            state_q <= OUT_IDLE;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            state_q <= state_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign out_valid = (state_q == OUT_VALID);

endmodule : adder_8bit

`default_nettype wire

// File: tb/tb_adder_8bit.sv
// ============================================================================
// Module : tb_adder_8bit
// Brief  : Scoreboard bench for adder_8bit: directed vectors, hold, reset, random.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_adder_8bit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             out_valid;

    int n_checks;
    int n_fail;

    logic [WIDTH:0] sb_q[$];
    logic [WIDTH:0] last_exp;

    adder_8bit #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and checks the result.
    task automatic run_cycle(input logic v, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic cv, input string tag);
        logic [WIDTH:0] exp;
        a        = av;
        b        = bv;
        carry_in = cv;
        in_valid = v;
        if (v) sb_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
        @(posedge clk);
        #1;
        check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            if (sb_q.size() == 0) begin
                check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp      = sb_q.pop_front();
                last_exp = exp;
            end
        end
        check_val({tag, "_sum"}, {{(32-WIDTH){1'b0}}, sum}, {{(32-WIDTH){1'b0}}, last_exp[WIDTH-1:0]});
        check_val({tag, "_cout"}, {31'd0, carry_out}, {31'd0, last_exp[WIDTH]});
    endtask

    // Asserts reset mid-cycle; whatever is on the inputs is an in-flight item to discard.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_val({tag, "_rst_sum"},   {{(32-WIDTH){1'b0}}, sum}, 32'd0);
        check_val({tag, "_rst_cout"},  {31'd0, carry_out}, 32'd0);
        check_val({tag, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        sb_q.delete();
        last_exp = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_rst_hold"}, {23'd0, out_valid, carry_out, sum}, 32'd0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = '0;
        rst_n    = 1'b1;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        in_valid = 1'b0;

        @(posedge clk);
        #1;
        do_reset("init");

        run_cycle(1'b1, 8'h00, 8'h00, 1'b0, "zero");
        run_cycle(1'b1, 8'h02, 8'h03, 1'b0, "add23");
        run_cycle(1'b1, 8'h02, 8'h03, 1'b1, "add23c");
        run_cycle(1'b1, 8'hFF, 8'h02, 1'b0, "wrapFF02");
        run_cycle(1'b1, 8'hFF, 8'h01, 1'b1, "wrapFF01c");
        run_cycle(1'b1, 8'hFF, 8'hFF, 1'b1, "maxall");
        run_cycle(1'b0, 8'h12, 8'h34, 1'b1, "hold1");
        run_cycle(1'b0, 8'hAB, 8'hCD, 1'b0, "hold2");
        run_cycle(1'b1, 8'h80, 8'h80, 1'b0, "msb");
        run_cycle(1'b1, 8'h55, 8'hAA, 1'b1, "alt");

        a        = 8'h77;
        b        = 8'h99;
        carry_in = 1'b1;
        in_valid = 1'b1;
        do_reset("midop");
        run_cycle(1'b0, 8'h01, 8'h01, 1'b0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                carry_in = 1'($urandom);
                in_valid = 1'b1;
                do_reset("rnd_rst");
            end
            run_cycle(($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom),
                      1'($urandom), "rnd");
        end

        check_val("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_8bit

`default_nettype wire
